// File: rtl/mul_rs_dispatch_pkg.sv
`default_nettype none
// ============================================================================
// tomasulo_pkg : shared types and constants for the mul/div reservation station
// Rev 1.0
// ============================================================================
package tomasulo_pkg;

   localparam int TAG_W  = 3;
   localparam int DATA_W = 8;
   localparam int AGE_W  = 2;

   localparam logic [3:0] FUNC_MUL = 4'b0010;
   localparam logic [3:0] FUNC_DIV = 4'b0011;

   typedef struct packed {
      logic              busy;
      logic              disp;
      logic [3:0]        func;
      logic [3:0]        rd;
      logic [TAG_W-1:0]  rob;
      logic              s1_rdy;
      logic [DATA_W-1:0] s1_val;
      logic [TAG_W-1:0]  s1_tag;
      logic              s2_rdy;
      logic [DATA_W-1:0] s2_val;
      logic [TAG_W-1:0]  s2_tag;
      logic [AGE_W-1:0]  age;
   } rs_entry_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DISP = 2'd1,
      WAIT = 2'd2
   } disp_state_t;

endpackage
`default_nettype wire

// File: rtl/mul_rs_dispatch_if.sv
`default_nettype none
// ============================================================================
// mul_rs_dispatch_if : dispatch / completion bus to the mul/div execution unit
// Rev 1.0
// ============================================================================
interface mul_rs_dispatch_if #(
   parameter int DATA_W = 8,
   parameter int TAG_W  = 3
);
   logic              ex_b;
   logic [TAG_W-1:0]  rs_index;
   logic [DATA_W-1:0] rs1_data;
   logic [DATA_W-1:0] rs2_data;
   logic [3:0]        func;
   logic [TAG_W-1:0]  rob_ind;
   logic [3:0]        rd;
   logic              ex_done;
   logic [TAG_W-1:0]  ex_done_idx;

   modport master (
      output ex_b, rs_index, rs1_data, rs2_data, func, rob_ind, rd,
      input  ex_done, ex_done_idx
   );

   modport slave (
      input  ex_b, rs_index, rs1_data, rs2_data, func, rob_ind, rd,
      output ex_done, ex_done_idx
   );
endinterface
`default_nettype wire

// File: rtl/mul_rs_dispatch_age_select.sv
`default_nettype none
// ============================================================================
// rs_age_select : combinational picker of the oldest (highest-age) ready entry
// Rev 1.0
// ============================================================================
module rs_age_select #(
   parameter int RS_DEPTH = 3,
   parameter int AGE_W    = 2,
   parameter int IDX_W    = 2
) (
   input  logic [RS_DEPTH-1:0]            req,
   input  logic [RS_DEPTH-1:0][AGE_W-1:0] age,
   output logic                           valid,
   output logic [IDX_W-1:0]               idx
);

   logic [AGE_W-1:0] w_best;

   always_comb begin
      valid  = 1'b0;
      idx    = '0;
      w_best = '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
         if (req[i] && (!valid || (age[i] > w_best))) begin
            valid  = 1'b1;
            idx    = IDX_W'(i);
            w_best = age[i];
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/mul_rs_dispatch.sv
`default_nettype none
// ============================================================================
// mul_rs_dispatch : mul/div reservation station with single-issue dispatch FSM
// Rev 1.0
// ============================================================================
module mul_rs_dispatch
   import tomasulo_pkg::*;
#(
   parameter int RS_DEPTH = 3,
   parameter int DATA_W   = tomasulo_pkg::DATA_W,
   parameter int TAG_W    = tomasulo_pkg::TAG_W
) (
   input  logic              clk1,
   input  logic              rst_n,
   input  logic              iss_valid,
   output logic              iss_ready,
   input  logic [3:0]        iss_func,
   input  logic [3:0]        iss_rd,
   input  logic [TAG_W-1:0]  iss_rob,
   input  logic              iss_s1_rdy,
   input  logic              iss_s2_rdy,
   input  logic [DATA_W-1:0] iss_s1_val,
   input  logic [DATA_W-1:0] iss_s2_val,
   input  logic [TAG_W-1:0]  iss_s1_tag,
   input  logic [TAG_W-1:0]  iss_s2_tag,
   input  logic              cdb_valid,
   input  logic [TAG_W-1:0]  cdb_tag,
   input  logic [DATA_W-1:0] cdb_data,
   input  logic              flush,
   mul_rs_dispatch_if.master ex_if,
   output logic [2:0]        occupancy
);

   localparam int IDX_W = (RS_DEPTH > 2) ? 2 : 1;

   rs_entry_t   r_ent     [RS_DEPTH];
   rs_entry_t   w_ent_nxt [RS_DEPTH];
   rs_entry_t   w_new;
   disp_state_t r_state;
   disp_state_t w_state_nxt;

   logic [RS_DEPTH-1:0]            w_busy;
   logic [RS_DEPTH-1:0]            w_ready;
   logic [RS_DEPTH-1:0][AGE_W-1:0] w_age;
   logic                           w_sel_valid;
   logic [IDX_W-1:0]               w_sel_idx;
   logic                           w_free_found;
   logic [IDX_W-1:0]               w_free_idx;
   logic                           w_iss_fire;
   logic                           w_go_disp;
   logic                           w_done_ok;
   logic [IDX_W-1:0]               w_done_idx;
   logic [AGE_W-1:0]               w_done_age;
   logic [2:0]                     w_occ;
   logic                           w_ex_b;
   logic                           r_squash;

   logic [TAG_W-1:0]  r_rs_index;
   logic [DATA_W-1:0] r_rs1_data;
   logic [DATA_W-1:0] r_rs2_data;
   logic [3:0]        r_func;
   logic [TAG_W-1:0]  r_rob_ind;
   logic [3:0]        r_rd;

   for (genvar g = 0; g < RS_DEPTH; g++) begin : g_flat
      assign w_busy[g]  = r_ent[g].busy;
      assign w_ready[g] = r_ent[g].busy && !r_ent[g].disp && r_ent[g].s1_rdy && r_ent[g].s2_rdy;
      assign w_age[g]   = r_ent[g].age;
   end

   rs_age_select #(
      .RS_DEPTH (RS_DEPTH),
      .AGE_W    (AGE_W),
      .IDX_W    (IDX_W)
   ) u_age_select (
      .req   (w_ready),
      .age   (w_age),
      .valid (w_sel_valid),
      .idx   (w_sel_idx)
   );

   always_comb begin
      w_free_found = 1'b0;
      w_free_idx   = '0;
      for (int i = RS_DEPTH - 1; i >= 0; i--) begin
         if (!w_busy[i]) begin
            w_free_found = 1'b1;
            w_free_idx   = IDX_W'(i);
         end
      end
   end

   always_comb begin
      w_occ = '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
         w_occ = w_occ + {2'b00, w_busy[i]};
      end
   end

   assign iss_ready  = w_free_found;
   assign occupancy  = w_occ;
   assign w_iss_fire = iss_valid && w_free_found && !flush;
   assign w_go_disp  = (r_state == IDLE) && w_sel_valid && !flush;
   assign w_done_idx = r_rs_index[IDX_W-1:0];
   assign w_done_age = r_ent[w_done_idx].age;
   assign w_done_ok  = (r_state == WAIT) && ex_if.ex_done && !flush &&
                       (ex_if.ex_done_idx == r_rs_index);

   // Incoming operands can be satisfied by the CDB result of this same cycle.
   always_comb begin
      w_new        = '0;
      w_new.busy   = 1'b1;
      w_new.func   = iss_func;
      w_new.rd     = iss_rd;
      w_new.rob    = iss_rob;
      w_new.s1_tag = iss_s1_tag;
      w_new.s2_tag = iss_s2_tag;
      if (iss_s1_rdy) begin
         w_new.s1_rdy = 1'b1;
         w_new.s1_val = iss_s1_val;
      end else if (cdb_valid && (cdb_tag == iss_s1_tag)) begin
         w_new.s1_rdy = 1'b1;
         w_new.s1_val = cdb_data;
      end
      if (iss_s2_rdy) begin
         w_new.s2_rdy = 1'b1;
         w_new.s2_val = iss_s2_val;
      end else if (cdb_valid && (cdb_tag == iss_s2_tag)) begin
         w_new.s2_rdy = 1'b1;
         w_new.s2_val = cdb_data;
      end
   end

   always_comb begin
      for (int i = 0; i < RS_DEPTH; i++) begin
         w_ent_nxt[i] = r_ent[i];
         if (r_ent[i].busy) begin
            if (cdb_valid && !r_ent[i].s1_rdy && (r_ent[i].s1_tag == cdb_tag)) begin
               w_ent_nxt[i].s1_rdy = 1'b1;
               w_ent_nxt[i].s1_val = cdb_data;
            end
            if (cdb_valid && !r_ent[i].s2_rdy && (r_ent[i].s2_tag == cdb_tag)) begin
               w_ent_nxt[i].s2_rdy = 1'b1;
               w_ent_nxt[i].s2_val = cdb_data;
            end
            // Decrement before increment so a free+issue cycle keeps ages unique.
            if (w_done_ok && (r_ent[i].age > w_done_age)) begin
               w_ent_nxt[i].age = r_ent[i].age - 1'b1;
            end
            if (w_iss_fire && (w_ent_nxt[i].age < AGE_W'(RS_DEPTH - 1))) begin
               w_ent_nxt[i].age = w_ent_nxt[i].age + 1'b1;
            end
         end
         if (w_go_disp && (w_sel_idx == IDX_W'(i))) begin
            w_ent_nxt[i].disp = 1'b1;
         end
         if (w_done_ok && (w_done_idx == IDX_W'(i))) begin
            w_ent_nxt[i].busy = 1'b0;
            w_ent_nxt[i].disp = 1'b0;
         end
         if (w_iss_fire && (w_free_idx == IDX_W'(i))) begin
            w_ent_nxt[i] = w_new;
         end
         if (flush) begin
            w_ent_nxt[i].busy = 1'b0;
            w_ent_nxt[i].disp = 1'b0;
         end
      end
   end

   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < RS_DEPTH; i++) begin
            r_ent[i] <= '0;
         end
      end else begin
         for (int i = 0; i < RS_DEPTH; i++) begin
            r_ent[i] <= w_ent_nxt[i];
         end
      end
   end

   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE:    if (w_sel_valid) w_state_nxt = DISP;
         DISP:    w_state_nxt = WAIT;
         WAIT:    if (w_done_ok) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
      if (flush) begin
         w_state_nxt = IDLE;
      end
   end

   always_comb begin
      w_ex_b = (r_state == DISP);
   end

   // Operands are latched on the IDLE->DISP edge and held until the next dispatch.
   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         r_rs_index <= '0;
         r_rs1_data <= '0;
         r_rs2_data <= '0;
         r_func     <= '0;
         r_rob_ind  <= '0;
         r_rd       <= '0;
      end else if (w_go_disp) begin
         r_rs_index <= TAG_W'(w_sel_idx);
         r_rs1_data <= r_ent[w_sel_idx].s1_val;
         r_rs2_data <= r_ent[w_sel_idx].s2_val;
         r_func     <= r_ent[w_sel_idx].func;
         r_rob_ind  <= r_ent[w_sel_idx].rob;
         r_rd       <= r_ent[w_sel_idx].rd;
      end
   end

   // Remembers that an in-flight op was squashed so its late completion is tolerated.
   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         r_squash <= 1'b0;
      end else if (flush && (r_state != IDLE)) begin
         r_squash <= 1'b1;
      end else if (ex_if.ex_done) begin
         r_squash <= 1'b0;
      end
   end

   assign ex_if.ex_b     = w_ex_b;
   assign ex_if.rs_index = r_rs_index;
   assign ex_if.rs1_data = r_rs1_data;
   assign ex_if.rs2_data = r_rs2_data;
   assign ex_if.func     = r_func;
   assign ex_if.rob_ind  = r_rob_ind;
   assign ex_if.rd       = r_rd;

   a_done_legal: assert property (@(posedge clk1) disable iff (!rst_n)
      ex_if.ex_done |-> ((r_state == WAIT) && (ex_if.ex_done_idx == r_rs_index)) || r_squash || flush);

   a_func_legal: assert property (@(posedge clk1) disable iff (!rst_n)
      w_iss_fire |-> ((iss_func == FUNC_MUL) || (iss_func == FUNC_DIV)));

endmodule
`default_nettype wire
